// File: rtl/write_back.sv
// Final pipeline stage: picks the commit value, drives the register-file write port one
// cycle later, holds multi-cycle loads/UART reads while stalling upstream, counts retirements.
module write_back #(
    parameter int          INST_MEM_WIDTH = 2,
    parameter logic [31:0] RETIRED_INIT   = 32'd0
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      distinct,
    input  logic                      AorF,
    input  logic                      RegWrite,
    input  logic [1:0]                MemtoReg,
    input  logic [1:0]                RegDist,
    input  logic [4:0]                rt,
    input  logic [4:0]                rd,
    input  logic [31:0]               alu_result,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    input  logic                      mem_rvalid,
    input  logic [31:0]               mem_rdata,
    input  logic                      uart_rvalid,
    input  logic [7:0]                uart_rdata,
    output logic                      uart_rready,
    output logic                      stall,
    output logic                      RegWrite_before,
    output logic                      AorF_before,
    output logic                      distinct_before,
    output logic [4:0]                rw,
    output logic [31:0]               write_data,
    output logic [31:0]               retired,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MEM  = 2'd1,
        WAIT_UART = 2'd2
    } state_t;

    state_t state, state_nx;

    logic       cap_aorf, cap_regwrite, cap_nowrite;
    logic [4:0] cap_idx;

    logic       in_nowrite;
    logic [4:0] in_idx;
    logic       commit;
    logic       c_aorf, c_regwrite, c_nowrite;
    logic [4:0] c_idx;
    logic [31:0] c_data;

    assign state_dbg = state;

    always_comb begin
        in_idx     = 5'd0;
        in_nowrite = 1'b0;
        case (RegDist)
            2'b00:   in_idx = rt;
            2'b01:   in_idx = rd;
            2'b10:   in_idx = 5'd31;
            default: in_nowrite = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (distinct && MemtoReg == 2'b01) state_nx = WAIT_MEM;
                else if (distinct && MemtoReg == 2'b11) state_nx = WAIT_UART;
            end
            WAIT_MEM:  if (mem_rvalid)  state_nx = IDLE;
            WAIT_UART: if (uart_rvalid) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Handshakes: stall tells upstream to hold its bundle; it drops in the completion
    // cycle, but a new bundle is only taken from IDLE. uart_rready is a same-cycle pop.
    always_comb begin
        commit      = 1'b0;
        stall       = 1'b0;
        uart_rready = 1'b0;
        c_aorf      = AorF;
        c_regwrite  = RegWrite;
        c_nowrite   = in_nowrite;
        c_idx       = in_idx;
        c_data      = alu_result;
        case (state)
            IDLE: begin
                if (distinct) begin
                    if (MemtoReg[0]) begin
                        stall = 1'b1;
                    end else begin
                        commit = 1'b1;
                        c_data = MemtoReg[1] ? 32'(pc1) : alu_result;
                    end
                end
            end
            WAIT_MEM: begin
                c_aorf     = cap_aorf;
                c_regwrite = cap_regwrite;
                c_nowrite  = cap_nowrite;
                c_idx      = cap_idx;
                c_data     = mem_rdata;
                stall      = !mem_rvalid;
                commit     = mem_rvalid;
            end
            WAIT_UART: begin
                c_aorf      = cap_aorf;
                c_regwrite  = cap_regwrite;
                c_nowrite   = cap_nowrite;
                c_idx       = cap_idx;
                c_data      = {24'b0, uart_rdata};
                stall       = !uart_rvalid;
                uart_rready = uart_rvalid;
                commit      = uart_rvalid;
            end
            default: ;
        endcase
    end

    // Bundle is frozen for the whole wait so upstream changes cannot leak in.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cap_aorf     <= 1'b0;
            cap_regwrite <= 1'b0;
            cap_nowrite  <= 1'b0;
            cap_idx      <= 5'd0;
        end else if (state == IDLE && distinct && MemtoReg[0]) begin
            cap_aorf     <= AorF;
            cap_regwrite <= RegWrite;
            cap_nowrite  <= in_nowrite;
            cap_idx      <= in_idx;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            RegWrite_before <= 1'b0;
            AorF_before     <= 1'b0;
            distinct_before <= 1'b0;
            rw              <= 5'd0;
            write_data      <= 32'd0;
            retired         <= RETIRED_INIT;
        end else if (commit) begin
            // Integer r0 is hard-wired; the instruction still retires.
            RegWrite_before <= c_regwrite && !c_nowrite && !(!c_aorf && c_idx == 5'd0);
            AorF_before     <= c_aorf;
            distinct_before <= 1'b1;
            rw              <= c_idx;
            write_data      <= c_data;
            retired         <= retired + 32'd1;
        end else begin
            RegWrite_before <= 1'b0;
            distinct_before <= 1'b0;
        end
    end

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: commits are predicted into a queue and checked by a
// monitor; stall/uart_rready/reset behaviour is checked inline.
module tb_write_back;
    logic        CLK = 1'b0;
    logic        reset;
    logic        distinct, AorF, RegWrite;
    logic [1:0]  MemtoReg, RegDist;
    logic [4:0]  rt, rd;
    logic [31:0] alu_result;
    logic [1:0]  pc1;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        uart_rvalid;
    logic [7:0]  uart_rdata;
    logic        uart_rready, stall, RegWrite_before, AorF_before, distinct_before;
    logic [4:0]  rw;
    logic [31:0] write_data, retired;
    logic [1:0]  state_dbg;

    logic        w_uart_rready, w_stall, w_we, w_aorf, w_dist;
    logic [4:0]  w_rw;
    logic [31:0] w_data, w_retired;
    logic [1:0]  w_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_retired = 32'd0;
    logic [70:0] exp_q[$];

    always #5 CLK = ~CLK;

    write_back #(.INST_MEM_WIDTH(2)) dut (
        .CLK(CLK), .reset(reset), .distinct(distinct), .AorF(AorF), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .RegDist(RegDist), .rt(rt), .rd(rd), .alu_result(alu_result),
        .pc1(pc1), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .uart_rvalid(uart_rvalid),
        .uart_rdata(uart_rdata), .uart_rready(uart_rready), .stall(stall),
        .RegWrite_before(RegWrite_before), .AorF_before(AorF_before),
        .distinct_before(distinct_before), .rw(rw), .write_data(write_data),
        .retired(retired), .state_dbg(state_dbg)
    );

    write_back #(.INST_MEM_WIDTH(2), .RETIRED_INIT(32'hFFFF_FFFF)) dut_wrap (
        .CLK(CLK), .reset(reset), .distinct(distinct), .AorF(AorF), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .RegDist(RegDist), .rt(rt), .rd(rd), .alu_result(alu_result),
        .pc1(pc1), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .uart_rvalid(uart_rvalid),
        .uart_rdata(uart_rdata), .uart_rready(w_uart_rready), .stall(w_stall),
        .RegWrite_before(w_we), .AorF_before(w_aorf), .distinct_before(w_dist),
        .rw(w_rw), .write_data(w_data), .retired(w_retired), .state_dbg(w_state)
    );

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic we, input logic aorf, input logic [4:0] idx,
                            input logic [31:0] data);
        exp_retired = exp_retired + 32'd1;
        exp_q.push_back({we, aorf, idx, data, exp_retired});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_bundle(input logic aorf, input logic we, input logic [1:0] m2r,
                              input logic [1:0] dsel, input logic [4:0] t, input logic [4:0] d,
                              input logic [31:0] alu, input logic [1:0] pc);
        distinct = 1'b1; AorF = aorf; RegWrite = we; MemtoReg = m2r; RegDist = dsel;
        rt = t; rd = d; alu_result = alu; pc1 = pc;
    endtask

    task automatic send(input logic aorf, input logic we, input logic [1:0] m2r,
                        input logic [1:0] dsel, input logic [4:0] t, input logic [4:0] d,
                        input logic [31:0] alu, input logic [1:0] pc);
        logic [1:0] m2r_l;
        m2r_l = m2r;
        set_bundle(aorf, we, m2r, dsel, t, d, alu, pc);
        @(negedge CLK);
        check("stall_on_accept", 71'(stall), 71'(m2r_l[0]));
        tick();
        distinct = 1'b0;
    endtask

    // Monitor: every retirement strobe must match the oldest prediction.
    always @(negedge CLK) begin
        if (distinct_before) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit", {RegWrite_before, AorF_before, rw, write_data, retired},
                      71'(0));
                if ({RegWrite_before, AorF_before, rw, write_data, retired} == 71'(0))
                    check("unexpected_commit_strobe", 71'(distinct_before), 71'(0));
            end else begin
                check("commit", {RegWrite_before, AorF_before, rw, write_data, retired},
                      exp_q.pop_front());
            end
        end else if (RegWrite_before) begin
            check("write_without_retire", 71'(RegWrite_before), 71'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; distinct = 1'b0; AorF = 1'b0; RegWrite = 1'b0; MemtoReg = 2'b00;
        RegDist = 2'b00; rt = 5'd0; rd = 5'd0; alu_result = 32'd0; pc1 = 2'b00;
        mem_rvalid = 1'b0; mem_rdata = 32'd0; uart_rvalid = 1'b0; uart_rdata = 8'd0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_regwrite", 71'(RegWrite_before), 71'(0));
        check("rst_distinct", 71'(distinct_before), 71'(0));
        check("rst_aorf", 71'(AorF_before), 71'(0));
        check("rst_rw", 71'(rw), 71'(0));
        check("rst_write_data", 71'(write_data), 71'(0));
        check("rst_retired", 71'(retired), 71'(0));
        check("rst_stall", 71'(stall), 71'(0));
        check("rst_uart_rready", 71'(uart_rready), 71'(0));
        check("rst_state", 71'(state_dbg), 71'(0));
        check("wrap_preload", 71'(w_retired), 71'(32'hFFFF_FFFF));
        tick();
        reset = 1'b1;
        tick();

        // ALU write to rd=5; the preloaded counter wraps on this first commit
        push_exp(1'b1, 1'b0, 5'd5, 32'h1234_5678);
        send(1'b0, 1'b1, 2'b00, 2'b01, 5'd3, 5'd5, 32'h1234_5678, 2'b00);
        @(negedge CLK);
        check("retired_wrap", 71'(w_retired), 71'(0));
        tick();

        // r0 integer suppressed, f0 writable, RegWrite=0 still retires
        push_exp(1'b0, 1'b0, 5'd0, 32'hCAFE_0001);
        send(1'b0, 1'b1, 2'b00, 2'b01, 5'd2, 5'd0, 32'hCAFE_0001, 2'b00);
        push_exp(1'b1, 1'b1, 5'd0, 32'hCAFE_0002);
        send(1'b1, 1'b1, 2'b00, 2'b01, 5'd2, 5'd0, 32'hCAFE_0002, 2'b00);
        push_exp(1'b0, 1'b0, 5'd9, 32'h0000_0055);
        send(1'b0, 1'b0, 2'b00, 2'b01, 5'd2, 5'd9, 32'h0000_0055, 2'b00);

        // Spurious mem_rvalid in IDLE
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        @(negedge CLK);
        check("idle_rvalid_stall", 71'(stall), 71'(0));
        tick();
        mem_rvalid = 1'b0;
        tick();

        // Load, k=3, upstream fields change during the wait
        send(1'b0, 1'b1, 2'b01, 2'b00, 5'd7, 5'd1, 32'h0000_1111, 2'b00);
        rt = 5'd20; RegDist = 2'b01; AorF = 1'b1; RegWrite = 1'b0;
        @(negedge CLK);
        check("load_stall_n1", 71'(stall), 71'(1));
        check("load_state", 71'(state_dbg), 71'(1));
        tick();
        @(negedge CLK);
        check("load_stall_n2", 71'(stall), 71'(1));
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        push_exp(1'b1, 1'b0, 5'd7, 32'hDEAD_BEEF);
        @(negedge CLK);
        check("load_stall_done", 71'(stall), 71'(0));
        tick();
        mem_rvalid = 1'b0;
        tick();

        // UART: byte arrives after 5 idle cycles
        send(1'b0, 1'b1, 2'b11, 2'b00, 5'd12, 5'd1, 32'h0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("uart_wait_rready", 71'(uart_rready), 71'(0));
            check("uart_wait_stall", 71'(stall), 71'(1));
            tick();
        end
        uart_rvalid = 1'b1; uart_rdata = 8'h41;
        push_exp(1'b1, 1'b0, 5'd12, 32'h0000_0041);
        @(negedge CLK);
        check("uart_rready_pulse", 71'(uart_rready), 71'(1));
        check("uart_stall_done", 71'(stall), 71'(0));
        tick();
        @(negedge CLK);
        check("uart_rready_once", 71'(uart_rready), 71'(0));
        tick();
        uart_rvalid = 1'b0;

        // Link to r31
        push_exp(1'b1, 1'b0, 5'd31, 32'h0000_0003);
        send(1'b0, 1'b1, 2'b10, 2'b10, 5'd1, 5'd2, 32'h0000_FFFF, 2'b11);

        // Back-to-back: new bundle in completion cycle is taken only one cycle later
        send(1'b0, 1'b1, 2'b01, 2'b01, 5'd0, 5'd14, 32'h0, 2'b00);
        set_bundle(1'b0, 1'b1, 2'b00, 2'b01, 5'd0, 5'd15, 32'h0000_A5A5, 2'b00);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        push_exp(1'b1, 1'b0, 5'd14, 32'h0BAD_F00D);
        @(negedge CLK);
        check("b2b_stall_done", 71'(stall), 71'(0));
        tick();
        mem_rvalid = 1'b0;
        push_exp(1'b1, 1'b0, 5'd15, 32'h0000_A5A5);
        @(negedge CLK);
        check("b2b_stall_alu", 71'(stall), 71'(0));
        tick();
        distinct = 1'b0;
        tick();

        // Reset during WAIT_MEM drops the load
        send(1'b0, 1'b1, 2'b01, 2'b00, 5'd3, 5'd1, 32'h0, 2'b00);
        @(negedge CLK);
        check("rst_wait_stall_before", 71'(stall), 71'(1));
        #2 reset = 1'b0;
        #1;
        check("async_rst_stall", 71'(stall), 71'(0));
        check("async_rst_retired", 71'(retired), 71'(0));
        check("async_rst_state", 71'(state_dbg), 71'(0));
        check("async_rst_wdata", 71'(write_data), 71'(0));
        exp_retired = 32'd0;
        tick();
        tick();
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
        @(negedge CLK);
        check("post_rst_stall", 71'(stall), 71'(0));
        tick();
        mem_rvalid = 1'b0;
        @(negedge CLK);
        check("post_rst_retired", 71'(retired), 71'(0));
        tick();

        // Counter restarts after reset
        push_exp(1'b1, 1'b0, 5'd4, 32'h0000_0042);
        send(1'b0, 1'b1, 2'b00, 2'b01, 5'd1, 5'd4, 32'h0000_0042, 2'b00);
        repeat (3) tick();

        check("queue_drained", 71'(exp_q.size()), 71'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
